// File: rtl/lagarto_dcache_req_buffer.sv
// Lagarto dcache request buffer: up to DEPTH tagged outstanding requests with
// out-of-order responses, nack replay, in-order retirement and pipeline flush.
module lagarto_dcache_req_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 64,
  parameter  int DATA_W = 64,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic              req_is_amo_i,
  input  logic [ADDR_W-1:0] req_rs1_i,
  input  logic [ADDR_W-1:0] req_imm_i,
  input  logic [1:0]        req_size_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_we_o,
  output logic [7:0]        mem_req_be_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [TAG_W-1:0]  mem_req_tag_o,
  input  logic              mem_resp_valid_i,
  input  logic              mem_resp_nack_i,
  input  logic [TAG_W-1:0]  mem_resp_tag_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic              cpu_resp_valid_o,
  output logic              cpu_resp_is_store_o,
  output logic [DATA_W-1:0] cpu_resp_data_o,
  output logic [ADDR_W-1:0] cpu_resp_addr_o,
  output logic              cpu_resp_xcpt_ma_o,
  output logic [TAG_W:0]    occupancy_o
);

  typedef enum logic [2:0] {
    ST_FREE, ST_WAIT, ST_INFL, ST_DONE, ST_KWAIT, ST_KDONE
  } entryState_e;

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  entryState_e       state_q [DEPTH];
  entryState_e       state_d [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic              store_q [DEPTH];
  logic              store_d [DEPTH];
  logic              xcpt_q  [DEPTH];
  logic              xcpt_d  [DEPTH];
  logic [7:0]        be_q    [DEPTH];
  logic [7:0]        be_d    [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];
  logic [DATA_W-1:0] rdata_q [DEPTH];
  logic [DATA_W-1:0] rdata_d [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              lockValid_q, lockValid_d;
  logic [TAG_W-1:0]  lockTag_q, lockTag_d;
  logic              cpuValid_q, cpuValid_d, cpuStore_q, cpuStore_d;
  logic              cpuXcpt_q, cpuXcpt_d;
  logic [DATA_W-1:0] cpuData_q, cpuData_d;
  logic [ADDR_W-1:0] cpuAddr_q, cpuAddr_d;

  logic [ADDR_W-1:0] allocAddr;
  logic              allocMis, allocFire, retireFree, waitFound;
  logic [7:0]        beMask, allocBe;
  logic [DATA_W-1:0] allocWdata;
  logic [TAG_W-1:0]  waitTag, scanTag, memTag;

  assign req_ready_o = !rst_i && (count_q < FULL_COUNT) && !flush_i;
  assign allocFire   = req_valid_i && req_ready_o;

  always_comb begin
    allocAddr = req_is_amo_i ? req_rs1_i : req_rs1_i + req_imm_i;
    allocMis  = 1'b0;
    beMask    = 8'h01;
    case (req_size_i)
      2'd0:    begin allocMis = 1'b0;            beMask = 8'h01; end
      2'd1:    begin allocMis = allocAddr[0];    beMask = 8'h03; end
      2'd2:    begin allocMis = |allocAddr[1:0]; beMask = 8'h0F; end
      default: begin allocMis = |allocAddr[2:0]; beMask = 8'hFF; end
    endcase
    allocBe    = beMask << allocAddr[2:0];
    allocWdata = req_wdata_i << {allocAddr[2:0], 3'b000};
  end

  // Oldest WAIT entry, scanning forward from the retire pointer.
  always_comb begin
    waitFound = 1'b0;
    waitTag   = head_q;
    scanTag   = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scanTag = head_q + TAG_W'(k);
      if (!waitFound && state_q[scanTag] == ST_WAIT) begin
        waitFound = 1'b1;
        waitTag   = scanTag;
      end
    end
  end

  // A presented request stays locked until accepted so the dcache sees stable fields.
  assign mem_req_valid_o = lockValid_q || waitFound;
  assign memTag          = lockValid_q ? lockTag_q : waitTag;
  assign mem_req_tag_o   = mem_req_valid_o ? memTag : '0;
  assign mem_req_addr_o  = mem_req_valid_o ? addr_q[memTag] : '0;
  assign mem_req_we_o    = mem_req_valid_o && store_q[memTag];
  assign mem_req_be_o    = mem_req_valid_o ? be_q[memTag] : '0;
  assign mem_req_wdata_o = mem_req_valid_o ? wdata_q[memTag] : '0;
  assign lockValid_d     = mem_req_valid_o && !mem_req_ready_i && !flush_i;
  assign lockTag_d       = memTag;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    xcpt_d     = xcpt_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    head_d     = head_q;
    tail_d     = tail_q;
    retireFree = 1'b0;
    cpuValid_d = 1'b0;
    cpuStore_d = 1'b0;
    cpuXcpt_d  = 1'b0;
    cpuData_d  = '0;
    cpuAddr_d  = '0;

    if (mem_req_valid_o && mem_req_ready_i) state_d[memTag] = ST_INFL;

    if (mem_resp_valid_i) begin
      case (state_q[mem_resp_tag_i])
        ST_INFL: begin
          if (mem_resp_nack_i) begin
            state_d[mem_resp_tag_i] = ST_WAIT;
          end else begin
            state_d[mem_resp_tag_i] = ST_DONE;
            rdata_d[mem_resp_tag_i] = mem_resp_data_i;
          end
        end
        ST_KWAIT: state_d[mem_resp_tag_i] = ST_KDONE;
        default: ;
      endcase
    end

    // Flush is applied after issue/response so it overrides both in the same cycle.
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        case (state_d[i])
          ST_WAIT, ST_DONE: state_d[i] = ST_KDONE;
          ST_INFL:          state_d[i] = ST_KWAIT;
          default: ;
        endcase
      end
    end

    case (state_d[head_q])
      ST_DONE: begin
        cpuValid_d      = 1'b1;
        cpuStore_d      = store_d[head_q];
        cpuXcpt_d       = xcpt_d[head_q];
        cpuData_d       = rdata_d[head_q];
        cpuAddr_d       = addr_d[head_q];
        state_d[head_q] = ST_FREE;
        retireFree      = 1'b1;
      end
      ST_KDONE: begin
        state_d[head_q] = ST_FREE;
        retireFree      = 1'b1;
      end
      default: ;
    endcase
    if (retireFree) head_d = head_q + TAG_W'(1);

    if (allocFire) begin
      state_d[tail_q] = allocMis ? ST_DONE : ST_WAIT;
      addr_d[tail_q]  = allocAddr;
      store_d[tail_q] = req_is_store_i;
      xcpt_d[tail_q]  = allocMis;
      be_d[tail_q]    = allocBe;
      wdata_d[tail_q] = allocWdata;
      rdata_d[tail_q] = '0;
      tail_d          = tail_q + TAG_W'(1);
    end

    count_d = count_q + {{TAG_W{1'b0}}, allocFire} - {{TAG_W{1'b0}}, retireFree};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        addr_q[i]  <= '0;
        store_q[i] <= 1'b0;
        xcpt_q[i]  <= 1'b0;
        be_q[i]    <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      lockValid_q <= 1'b0;
      lockTag_q   <= '0;
      cpuValid_q  <= 1'b0;
      cpuStore_q  <= 1'b0;
      cpuXcpt_q   <= 1'b0;
      cpuData_q   <= '0;
      cpuAddr_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      xcpt_q      <= xcpt_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      lockValid_q <= lockValid_d;
      lockTag_q   <= lockTag_d;
      cpuValid_q  <= cpuValid_d;
      cpuStore_q  <= cpuStore_d;
      cpuXcpt_q   <= cpuXcpt_d;
      cpuData_q   <= cpuData_d;
      cpuAddr_q   <= cpuAddr_d;
    end
  end

  assign cpu_resp_valid_o    = cpuValid_q;
  assign cpu_resp_is_store_o = cpuStore_q;
  assign cpu_resp_xcpt_ma_o  = cpuXcpt_q;
  assign cpu_resp_data_o     = cpuData_q;
  assign cpu_resp_addr_o     = cpuAddr_q;
  assign occupancy_o         = count_q;

endmodule
